// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the classifier datapath (sfix26_En18).
package nn_fixed_pkg;

  localparam int unsigned NN_ACC_WIDTH = 26;
  localparam int unsigned NN_FRAC_BITS = 18;

  typedef logic signed [NN_ACC_WIDTH-1:0] acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(NN_ACC_WIDTH-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(NN_ACC_WIDTH-1){1'b0}}};

  // Add at one extra bit, then clamp; the top two bits of the wide sum disagree on overflow.
  function automatic acc_t sat_add(input acc_t a, input acc_t b);
    logic [NN_ACC_WIDTH:0] sum;
    acc_t                  res;
    sum = {a[NN_ACC_WIDTH-1], a} + {b[NN_ACC_WIDTH-1], b};
    if (!sum[NN_ACC_WIDTH] && sum[NN_ACC_WIDTH-1]) begin
      res = ACC_MAX;
    end else if (sum[NN_ACC_WIDTH] && !sum[NN_ACC_WIDTH-1]) begin
      res = ACC_MIN;
    end else begin
      res = acc_t'(sum[NN_ACC_WIDTH-1:0]);
    end
    return res;
  endfunction

endpackage

// File: rtl/neuron_argmax_stage_if.sv
// Streaming bus between the MAC and the argmax stage, plus the stage's result strobes.
interface neuron_argmax_stage_if
  import nn_fixed_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = NN_ACC_WIDTH,
  parameter int unsigned IDX_WIDTH = 4
);

  logic [ACC_WIDTH-1:0] acc_in;
  logic                 acc_valid;
  logic [ACC_WIDTH-1:0] act_out;
  logic [IDX_WIDTH-1:0] act_idx;
  logic                 act_valid;
  logic [IDX_WIDTH-1:0] class_out;
  logic [ACC_WIDTH-1:0] max_out;
  logic                 class_valid;

  modport master (
    output acc_in, acc_valid,
    input  act_out, act_idx, act_valid, class_out, max_out, class_valid
  );

  modport slave (
    input  acc_in, acc_valid,
    output act_out, act_idx, act_valid, class_out, max_out, class_valid
  );

endinterface

// File: rtl/relu_sat_add.sv
// Bias add with saturation (S1) followed by ReLU (S2), one register per stage.
module relu_sat_add
  import nn_fixed_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  acc_t                 in_acc,
  input  acc_t                 in_bias,
  input  logic [IDX_WIDTH-1:0] in_idx,
  output logic                 out_valid,
  output logic                 out_last,
  output acc_t                 out_act,
  output logic [IDX_WIDTH-1:0] out_idx
);

  logic                 s1_valid_q;
  logic                 s1_last_q;
  acc_t                 s1_sum_q;
  logic [IDX_WIDTH-1:0] s1_idx_q;

  // S1: saturating bias add; last flag is qualified by valid so it never leaks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_valid & in_last;
      if (in_valid) begin
        s1_sum_q <= sat_add(in_acc, in_bias);
        s1_idx_q <= in_idx;
      end
    end
  end

  // S2: ReLU on the saturated sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_act   <= '0;
      out_idx   <= '0;
    end else begin
      out_valid <= s1_valid_q;
      out_last  <= s1_last_q;
      if (s1_valid_q) begin
        out_act <= s1_sum_q[NN_ACC_WIDTH-1] ? '0 : s1_sum_q;
        out_idx <= s1_idx_q;
      end
    end
  end

endmodule

// File: rtl/neuron_argmax_stage.sv
// Per-neuron bias/ReLU activation and per-frame running argmax over NUM_NEURONS results.
module neuron_argmax_stage
  import nn_fixed_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned ACC_WIDTH   = NN_ACC_WIDTH,
  parameter int unsigned IDX_WIDTH   = 4
) (
  input logic                             clk,
  input logic                             rst,
  input logic [NUM_NEURONS*ACC_WIDTH-1:0] IN_BIASES,
  neuron_argmax_stage_if.slave            bus
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_NEURONS - 1);

  logic [IDX_WIDTH-1:0] nidx_q;
  logic                 in_last;
  acc_t                 bias_arr [NUM_NEURONS];

  logic                 s2_valid;
  logic                 s2_last;
  acc_t                 s2_act;
  logic [IDX_WIDTH-1:0] s2_idx;

  acc_t                 run_max_q;
  logic [IDX_WIDTH-1:0] run_idx_q;
  acc_t                 max_out_q;
  logic [IDX_WIDTH-1:0] class_out_q;
  logic                 class_valid_q;

  logic                 take;
  acc_t                 win_max;
  logic [IDX_WIDTH-1:0] win_idx;

  for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_bias
    assign bias_arr[k] = IN_BIASES[k*ACC_WIDTH +: ACC_WIDTH];
  end

  assign in_last = (nidx_q == LastIdx);

  // Input neuron counter, wraps at the end of each frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nidx_q <= '0;
    end else if (bus.acc_valid) begin
      nidx_q <= in_last ? '0 : nidx_q + 1'b1;
    end
  end

  relu_sat_add #(
    .IDX_WIDTH (IDX_WIDTH)
  ) u_relu_sat_add (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.acc_valid),
    .in_last   (in_last),
    .in_acc    (bus.acc_in),
    .in_bias   (bias_arr[nidx_q]),
    .in_idx    (nidx_q),
    .out_valid (s2_valid),
    .out_last  (s2_last),
    .out_act   (s2_act),
    .out_idx   (s2_idx)
  );

  // Neuron 0 seeds the frame; later neurons must be strictly greater, so ties keep the lower index.
  always_comb begin
    take    = s2_valid && ((s2_idx == '0) || (s2_act > run_max_q));
    win_max = take ? s2_act : run_max_q;
    win_idx = take ? s2_idx : run_idx_q;
  end

  // S3: running max plus frame-end result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_max_q     <= '0;
      run_idx_q     <= '0;
      max_out_q     <= '0;
      class_out_q   <= '0;
      class_valid_q <= 1'b0;
    end else begin
      class_valid_q <= s2_valid & s2_last;
      if (s2_valid) begin
        run_max_q <= win_max;
        run_idx_q <= win_idx;
      end
      if (s2_valid && s2_last) begin
        max_out_q   <= win_max;
        class_out_q <= win_idx;
      end
    end
  end

  assign bus.act_out     = s2_act;
  assign bus.act_idx     = s2_idx;
  assign bus.act_valid   = s2_valid;
  assign bus.class_out   = class_out_q;
  assign bus.max_out     = max_out_q;
  assign bus.class_valid = class_valid_q;

endmodule

// File: tb/tb_neuron_argmax_stage.sv
// Directed bench for neuron_argmax_stage: expectations are hand-computed constants.
module tb_neuron_argmax_stage;
  import nn_fixed_pkg::*;

  localparam int NUM = 10;
  localparam int AW  = 26;
  localparam int IW  = 4;
  localparam int ONE = 1 << NN_FRAC_BITS;

  logic              clk;
  logic              rst;
  logic [NUM*AW-1:0] biases;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [AW-1:0] act_q [$];
  logic [IW-1:0] idx_q [$];
  int            act_cyc_q [$];
  logic [IW-1:0] cls_q [$];
  logic [AW-1:0] max_q [$];
  int            cls_cyc_q [$];

  neuron_argmax_stage_if #(.ACC_WIDTH(AW), .IDX_WIDTH(IW)) bus ();

  neuron_argmax_stage #(
    .NUM_NEURONS (NUM),
    .ACC_WIDTH   (AW),
    .IDX_WIDTH   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .IN_BIASES (biases),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.act_valid) begin
      act_q.push_back(bus.act_out);
      idx_q.push_back(bus.act_idx);
      act_cyc_q.push_back(cyc);
    end
    if (bus.class_valid) begin
      cls_q.push_back(bus.class_out);
      max_q.push_back(bus.max_out);
      cls_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    act_q.delete(); idx_q.delete(); act_cyc_q.delete();
    cls_q.delete(); max_q.delete(); cls_cyc_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs change 1 time unit after an edge; each value is sampled on the next edge.
  task automatic feed(input logic [AW-1:0] v [NUM], input int gap,
                      output int first_cyc, output int last_cyc);
    first_cyc = 0;
    last_cyc  = 0;
    for (int k = 0; k < NUM; k++) begin
      if (k == 0) first_cyc = cyc;
      if (k == NUM - 1) last_cyc = cyc;
      bus.acc_in    = v[k];
      bus.acc_valid = 1'b1;
      tick(1);
      bus.acc_valid = 1'b0;
      if (gap > 1) tick(gap - 1);
    end
  endtask

  task automatic check_acts(input string name, input logic [AW-1:0] exp [NUM]);
    check({name, "_act_count"}, (act_q.size() >= NUM), 1);
    for (int k = 0; k < NUM && act_q.size() > 0; k++) begin
      check($sformatf("%s_act%0d", name, k), act_q.pop_front(), exp[k]);
      check($sformatf("%s_idx%0d", name, k), idx_q.pop_front(), k);
      void'(act_cyc_q.pop_front());
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_act_valid"}, bus.act_valid, 0);
    check({name, "_act_out"}, bus.act_out, 0);
    check({name, "_act_idx"}, bus.act_idx, 0);
    check({name, "_class_valid"}, bus.class_valid, 0);
    check({name, "_class_out"}, bus.class_out, 0);
    check({name, "_max_out"}, bus.max_out, 0);
  endtask

  initial begin
    logic [AW-1:0] v  [NUM];
    logic [AW-1:0] e  [NUM];
    logic [AW-1:0] v2 [NUM];
    logic [AW-1:0] e2 [NUM];
    int            t_first;
    int            t_last;
    int            t2_first;
    int            t2_last;

    rst           = 1'b0;
    biases        = '0;
    bus.acc_in    = '0;
    bus.acc_valid = 1'b0;
    tick(3);
    check_idle_outputs("reset");
    rst = 1'b1;
    tick(1);
    check_idle_outputs("post_reset");

    // Basic frame: ramp k*1.0, every 5 cycles, biases zero.
    for (int k = 0; k < NUM; k++) begin
      v[k] = AW'(k * ONE);
      e[k] = AW'(k * ONE);
    end
    feed(v, 5, t_first, t_last);
    tick(6);
    check("basic_act_latency", (act_cyc_q.size() > 0) ? act_cyc_q[0] - t_first : -1, 2);
    check_acts("basic", e);
    check("basic_class_count", cls_q.size(), 1);
    if (cls_q.size() > 0) begin
      check("basic_class", cls_q[0], 9);
      check("basic_max", max_q[0], 26'h240000);
      check("basic_class_latency", cls_cyc_q[0] - t_last, 3);
    end
    tick(4);
    check("basic_class_hold", bus.class_out, 9);
    check("basic_max_hold", bus.max_out, 26'h240000);
    clear_q();

    // Bias, ReLU and both saturation directions.
    for (int k = 0; k < NUM; k++) begin
      v[k] = '0;
      e[k] = '0;
    end
    v[0] = 26'h3FC0000; biases[0*AW +: AW] = 26'h0020000;
    v[1] = 26'h0040000; biases[1*AW +: AW] = 26'h3FE0000; e[1] = 26'h0020000;
    v[2] = 26'h1FFFFFF; biases[2*AW +: AW] = 26'h1FFFFFF; e[2] = 26'h1FFFFFF;
    v[3] = 26'h2000000; biases[3*AW +: AW] = 26'h3FFFFFF;
    feed(v, 2, t_first, t_last);
    tick(6);
    check_acts("bias", e);
    check("bias_class_count", cls_q.size(), 1);
    if (cls_q.size() > 0) begin
      check("bias_class", cls_q[0], 2);
      check("bias_max", max_q[0], 26'h1FFFFFF);
    end
    clear_q();
    biases = '0;

    // Two back-to-back frames: tie on 3/7, then neuron 0 strictly largest.
    for (int k = 0; k < NUM; k++) begin
      v[k]  = AW'(k * 26'h1000);
      e[k]  = v[k];
      v2[k] = 26'h80000;
      e2[k] = 26'h80000;
    end
    v[3] = 26'h80000; e[3] = 26'h80000;
    v[7] = 26'h80000; e[7] = 26'h80000;
    v2[0] = 26'h100000; e2[0] = 26'h100000;
    v2[9] = 26'h0FFFFF; e2[9] = 26'h0FFFFF;
    feed(v, 1, t_first, t_last);
    feed(v2, 1, t2_first, t2_last);
    tick(6);
    check_acts("tie", e);
    check_acts("b2b", e2);
    check("b2b_class_count", cls_q.size(), 2);
    if (cls_q.size() == 2) begin
      check("tie_class", cls_q[0], 3);
      check("tie_max", max_q[0], 26'h80000);
      check("b2b_class", cls_q[1], 0);
      check("b2b_max", max_q[1], 26'h100000);
      check("b2b_gap", cls_cyc_q[1] - cls_cyc_q[0], 10);
    end
    clear_q();

    // Reset after neuron 4 of a frame of large values.
    for (int k = 0; k < 5; k++) begin
      bus.acc_in    = 26'h1000000;
      bus.acc_valid = 1'b1;
      tick(1);
    end
    bus.acc_valid = 1'b0;
    rst = 1'b0;
    #1;
    check_idle_outputs("midreset");
    tick(2);
    rst = 1'b1;
    tick(1);
    clear_q();
    for (int k = 0; k < NUM; k++) begin
      v[k] = (k == 5) ? 26'h300000 : AW'((k + 1) * 26'h10000);
      e[k] = v[k];
    end
    feed(v, 1, t_first, t_last);
    check("midreset_no_early_class", cls_q.size(), 0);
    tick(6);
    check_acts("midreset", e);
    check("midreset_class_count", cls_q.size(), 1);
    if (cls_q.size() > 0) begin
      check("midreset_class", cls_q[0], 5);
      check("midreset_max", max_q[0], 26'h300000);
    end
    clear_q();

    // All-negative frame: every activation clamps to zero, neuron 0 wins.
    for (int k = 0; k < NUM; k++) begin
      v[k] = AW'(-(k + 1) * ONE);
      e[k] = '0;
    end
    feed(v, 3, t_first, t_last);
    tick(6);
    check_acts("neg", e);
    check("neg_class_count", cls_q.size(), 1);
    if (cls_q.size() > 0) begin
      check("neg_class", cls_q[0], 0);
      check("neg_max", max_q[0], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_argmax_stage.md
# neuron_argmax_stage

Consumes the serial dot-product results of the pipelined multiply-accumulate stage, one per neuron. For each result it adds that neuron's bias, saturates, and applies ReLU, then emits the activation. It also keeps a running argmax across the NUM_NEURONS results of a frame and reports the winning class index and its activation at frame end. It sits directly downstream of the MAC and is the last arithmetic stage before the classifier output.

## Interface
- NUM_NEURONS, 10: results per frame; must be ≥ 2.
- ACC_WIDTH, 26: accumulator, bias and activation width; sfix26_En18.
- IDX_WIDTH, 4: class index width; must satisfy 2^IDX_WIDTH ≥ NUM_NEURONS.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- acc_in  in  ACC_WIDTH  MAC dot-product result; sfix26_En18.
- acc_valid  in  1  one-cycle strobe, driven by MAC done; acc_in is sampled on the same edge.
- IN_BIASES  in  NUM_NEURONS*ACC_WIDTH  per-neuron bias, sfix26_En18; neuron k occupies slice [k*ACC_WIDTH +: ACC_WIDTH]; static during a frame.
- act_out  out  ACC_WIDTH  ReLU activation, ≥ 0.
- act_idx  out  IDX_WIDTH  neuron index of act_out.
- act_valid  out  1  one-cycle strobe qualifying act_out and act_idx.
- class_out  out  IDX_WIDTH  argmax index of the completed frame.
- max_out  out  ACC_WIDTH  activation of the winning neuron.
- class_valid  out  1  one-cycle strobe at frame end.

## Operation
- Input index counter nidx:
  - starts at 0 and increments on each acc_valid;
  - wraps from NUM_NEURONS-1 to 0;
  - the result captured with nidx = NUM_NEURONS-1 is the frame's last neuron.
- S1 (bias add):
  - sum = sign-extended acc_in + IN_BIASES[nidx], computed at ACC_WIDTH+1 bits;
  - clamp to [-2^25, 2^25-1];
  - register the result with its index and a last flag.
- S2 (ReLU): negative → 0, otherwise pass unchanged; register act_out, act_idx, act_valid.
- S3 (argmax):
  - The first neuron of a frame (index 0) loads the running max unconditionally.
  - Later neurons replace the running max only if strictly greater, so on a tie the lowest index wins.
  - When the last neuron is processed:
    - class_out and max_out take the final winner, including the last neuron if it wins;
    - class_valid pulses;
    - the running state is free for the next frame with no dead cycle.
- acc_valid may be asserted on consecutive cycles; the stage is fully pipelined and never stalls.
- There is no backpressure; downstream must accept every strobe.

## Timing
- acc_valid at edge T → act_valid at T+2.
- Last neuron's acc_valid at T → class_valid at T+3.
- class_out and max_out hold their values until the next frame's class_valid.
- Reset (rst low, asynchronous) clears:
  - nidx, all pipeline valids, act_out, act_idx, class_out, max_out and class_valid to 0;
  - all in-flight results, which are discarded;
  - the running max.
- Frame restart after reset: the first acc_valid after rst deasserts is neuron 0.
- Reset mid-frame: no class_valid is produced for the partial frame.
- Saturation happens only in S1. The ReLU output is never negative, and max_out never exceeds 2^25-1.

## Structure
- Shared package (nn_fixed_pkg):
  - ACC_WIDTH and the fractional-bit count 18;
  - the saturation bounds ACC_MAX and ACC_MIN;
  - the fixed-point helper for saturating add.
- One natural sub-module, relu_sat_add: the S1+S2 arithmetic datapath (add, clamp, ReLU), registered at each stage.
- Top level holds nidx, the S3 comparator and the output registers.

## Test plan
- Basic frame:
  - stimulus: NUM_NEURONS=10, biases 0, acc_in = k*0x40000 (k = 0..9), one per 5 cycles;
  - required: ten act_valid strobes with act_out = acc_in;
  - required: class_out = 9 and max_out = 0x240000, with class_valid 3 cycles after the last acc_valid.
- Bias and ReLU:
  - stimulus: acc_in = -0x40000 with bias 0x20000;
  - required: act_out = 0;
  - stimulus: acc_in = 0x40000 with bias -0x20000;
  - required: act_out = 0x20000.
- Saturation: acc_in = 0x1FFFFFF with bias 0x1FFFFFF → act_out = 0x1FFFFFF, no wrap.
- Tie and back-to-back:
  - stimulus: acc_valid every cycle, two consecutive frames;
  - required: frame 1 with neurons 3 and 7 both at 0x80000 as the maximum → class_out = 3;
  - required: frame 2 with neuron 0 strictly the largest → class_out = 0;
  - required: class_valid pulses exactly twice.
- Reset mid-frame:
  - stimulus: assert rst after neuron 4, then feed a full frame;
  - required: no class_valid before the new frame completes; result reflects only the new frame.
- All-negative frame: all activations 0 → class_out = 0, max_out = 0.
